// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - UART byte receiver assembling MSB-byte-first command words
module uart_cmd_rx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BR        = 115200,
    parameter int CMD_WIDTH = 16,
    parameter int CHEAK     = 1,
    parameter int GAP_BITS  = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [CMD_WIDTH-1:0] cmd_out,
    output logic                 cmd_vld,
    input  logic                 cmd_rdy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int DIV     = CLK_FREQ / BR;
    localparam int NBYTES  = CMD_WIDTH / 8;
    localparam int GAP_LIM = GAP_BITS * DIV;
    localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GAP_W   = $clog2(GAP_LIM + 1);
    localparam int IDX_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(DIV - 1);
    localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP_LIM - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
    localparam bit               HAS_PAR  = (CHEAK != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state, state_next;

    logic                 rx_s1, rxs, rxs_d;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           bit_cnt;
    logic [7:0]           shreg;
    logic                 par_bit;
    logic [IDX_W-1:0]     byte_idx;
    logic [GAP_W-1:0]     gap_cnt;
    logic [CMD_WIDTH-1:0] asm_reg;
    logic [CMD_WIDTH+7:0] asm_cat;
    logic [CMD_WIDTH-1:0] asm_next;

    logic bit_end, stop_sample, parity_ok, byte_good, gap_expire;

    assign bit_end     = (cnt == CNT_END);
    assign stop_sample = (state == STOP) && bit_end;
    assign parity_ok   = !HAS_PAR || (par_bit == ~^shreg);
    assign byte_good   = stop_sample && rxs && parity_ok;
    assign gap_expire  = (state == IDLE) && (byte_idx != '0) && (gap_cnt == GAP_END);
    assign asm_cat     = {asm_reg, shreg};
    assign asm_next    = asm_cat[CMD_WIDTH-1:0];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rxs_d && !rxs) state_next = START;
            START:   if (cnt == CNT_MID) state_next = rxs ? IDLE : DATA;
            DATA:    if (bit_end && bit_cnt == 3'd7) state_next = HAS_PAR ? PARITY : STOP;
            PARITY:  if (bit_end) state_next = STOP;
            STOP:    if (bit_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            rx_s1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
        end else begin
            state <= state_next;
            rx_s1 <= rx;
            rxs   <= rx_s1;
            rxs_d <= rxs;
        end
    end

    // Bit timing: counter restarts on every state change and at each bit boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            if (state == IDLE || state_next != state || bit_end)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (state == IDLE)
                bit_cnt <= '0;
            else if (state == DATA && bit_end)
                bit_cnt <= bit_cnt + 1'b1;
            if (state == DATA && bit_end)
                shreg <= {rxs, shreg[7:1]};
            if (state == PARITY && bit_end)
                par_bit <= rxs;
        end
    end

    // Inter-byte gap watchdog only runs while a partial word is pending.
    always_ff @(posedge clk) begin
        if (!rst_n)
            gap_cnt <= '0;
        else if (state != IDLE || byte_idx == '0 || gap_cnt == GAP_END)
            gap_cnt <= '0;
        else
            gap_cnt <= gap_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_idx   <= '0;
            asm_reg    <= '0;
            cmd_out    <= '0;
            cmd_vld    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            if (cmd_vld && cmd_rdy)
                cmd_vld <= 1'b0;
            if (gap_expire)
                byte_idx <= '0;
            if (stop_sample) begin
                if (!rxs) begin
                    frame_err <= 1'b1;
                    byte_idx  <= '0;
                end else if (!parity_ok) begin
                    parity_err <= 1'b1;
                    byte_idx   <= '0;
                end else begin
                    asm_reg <= asm_next;
                    if (byte_idx == IDX_LAST) begin
                        byte_idx <= '0;
                        if (!cmd_vld || cmd_rdy) begin
                            cmd_out <= asm_next;
                            cmd_vld <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb/tb_uart_cmd_rx.sv - self-checking bench for uart_cmd_rx
module tb_uart_cmd_rx;

    localparam int DIV      = 10;
    localparam int GAP_BITS = 20;

    typedef struct {
        logic [7:0] d;
        bit         par_ok;
        bit         stop_ok;
        int         idle;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        cmd_rdy = 1'b0;
    logic [15:0] cmd_out;
    logic        cmd_vld, parity_err, frame_err, overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int n_par, n_frm, n_ovr, vld_cycles;
    logic [15:0] got_q[$];

    uart_cmd_rx #(
        .CLK_FREQ (1000000),
        .BR       (100000),
        .CMD_WIDTH(16),
        .CHEAK    (1),
        .GAP_BITS (GAP_BITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .cmd_out   (cmd_out),
        .cmd_vld   (cmd_vld),
        .cmd_rdy   (cmd_rdy),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (parity_err) n_par++;
            if (frame_err) n_frm++;
            if (overrun) n_ovr++;
            if (cmd_vld) vld_cycles++;
            if (cmd_vld && cmd_rdy) got_q.push_back(cmd_out);
        end
    end

    task automatic clear_mon();
        n_par = 0; n_frm = 0; n_ovr = 0; vld_cycles = 0;
        got_q.delete();
    endtask

    task automatic bit_time(input logic b);
        rx = b;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit par_ok, input bit stop_ok, input int idle_bits);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
        bit_time((~^d) ^ !par_ok);
        bit_time(stop_ok);
        for (int i = 0; i < idle_bits; i++) bit_time(1'b1);
    endtask

    task automatic check_word(input string name, input logic [15:0] exp);
        n_cmp++;
        if (got_q.size() != 1) begin
            n_bad++;
            $display("FAIL %s: word count %0d, expected 1", name, got_q.size());
        end else if (got_q[0] !== exp) begin
            n_bad++;
            $display("FAIL %s: cmd_out %h, expected %h", name, got_q[0], exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({cmd_out, cmd_vld, parity_err, frame_err, overrun} !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h/%b%b%b%b, expected all 0", cmd_out, cmd_vld, parity_err, frame_err, overrun);
        end
        rst_n = 1'b1;
        bit_time(1'b1);
    endtask

    task automatic test_basic();
        int waited;
        clear_mon();
        cmd_rdy = 1'b1;
        send_byte(8'hA5, 1, 1, 2);
        send_byte(8'h3C, 1, 1, 0);
        waited = 0;
        while (got_q.size() == 0 && waited < 3 * DIV) begin
            @(posedge clk); #1; waited++;
        end
        bit_time(1'b1); bit_time(1'b1);
        check_word("basic_word", 16'hA53C);
        n_cmp++;
        if (vld_cycles != 1) begin
            n_bad++;
            $display("FAIL basic_vld_width: %0d cycles, expected 1", vld_cycles);
        end
        n_cmp++;
        if (n_par + n_frm + n_ovr != 0) begin
            n_bad++;
            $display("FAIL basic_errors: %0d pulses, expected 0", n_par + n_frm + n_ovr);
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (3 * DIV) @(posedge clk);
        #1;
        n_cmp++;
        if (vld_cycles + n_par + n_frm != 0) begin
            n_bad++;
            $display("FAIL glitch_quiet: vld %0d par %0d frm %0d, expected 0", vld_cycles, n_par, n_frm);
        end
        send_byte(8'h0F, 1, 1, 2);
        send_byte(8'hF0, 1, 1, 2);
        check_word("glitch_recover", 16'h0FF0);
    endtask

    task automatic test_parity();
        clear_mon();
        send_byte(8'hA5, 0, 1, 2);
        send_byte(8'h12, 1, 1, 2);
        send_byte(8'h34, 1, 1, 2);
        n_cmp++;
        if (n_par != 1) begin
            n_bad++;
            $display("FAIL parity_pulse: %0d pulses, expected 1", n_par);
        end
        check_word("parity_word", 16'h1234);
    endtask

    task automatic test_overrun();
        clear_mon();
        cmd_rdy = 1'b0;
        send_byte(8'h11, 1, 1, 2);
        send_byte(8'h11, 1, 1, 2);
        send_byte(8'h22, 1, 1, 2);
        send_byte(8'h22, 1, 1, 2);
        n_cmp++;
        if (cmd_vld !== 1'b1 || cmd_out !== 16'h1111) begin
            n_bad++;
            $display("FAIL overrun_hold: vld %b out %h, expected 1 1111", cmd_vld, cmd_out);
        end
        n_cmp++;
        if (n_ovr != 1) begin
            n_bad++;
            $display("FAIL overrun_pulse: %0d pulses, expected 1", n_ovr);
        end
        cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (cmd_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_release: vld %b, expected 0", cmd_vld);
        end
        check_word("overrun_accept", 16'h1111);
    endtask

    task automatic test_gap_frame();
        clear_mon();
        send_byte(8'hAB, 1, 1, 25);
        send_byte(8'hCD, 1, 1, 2);
        send_byte(8'hEF, 1, 1, 2);
        check_word("gap_word", 16'hCDEF);
        clear_mon();
        send_byte(8'h77, 1, 0, 2);
        send_byte(8'h66, 0, 0, 2);
        send_byte(8'h88, 1, 1, 2);
        send_byte(8'h99, 1, 1, 2);
        n_cmp++;
        if (n_frm != 2 || n_par != 0) begin
            n_bad++;
            $display("FAIL frame_pulses: frm %0d par %0d, expected 2 0", n_frm, n_par);
        end
        check_word("frame_word", 16'h8899);
    endtask

    task automatic test_reset_mid();
        clear_mon();
        send_byte(8'h12, 1, 1, 2);
        bit_time(1'b0);
        bit_time(1'b0);
        bit_time(1'b1);
        rx = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({cmd_out, cmd_vld, parity_err, frame_err, overrun} !== 20'h0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %h/%b%b%b%b, expected all 0", cmd_out, cmd_vld, parity_err, frame_err, overrun);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) bit_time(1'b1);
        send_byte(8'h5A, 1, 1, 2);
        send_byte(8'hC3, 1, 1, 2);
        check_word("midreset_word", 16'h5AC3);
    endtask

    task automatic test_random();
        rec_t        recs[$];
        rec_t        r;
        logic [15:0] exp_q[$];
        logic [15:0] acc;
        int          nbytes, prev_idle, e_par, e_frm;
        clear_mon();
        cmd_rdy = 1'b1;
        for (int i = 0; i < 24; i++) begin
            r.d       = 8'($urandom);
            r.par_ok  = ($urandom_range(0, 6) != 0);
            r.stop_ok = ($urandom_range(0, 6) != 0);
            r.idle    = ($urandom_range(0, 7) == 0) ? 25 : 2;
            recs.push_back(r);
            send_byte(r.d, r.par_ok, r.stop_ok, r.idle);
        end
        nbytes = 0; prev_idle = 2; e_par = 0; e_frm = 0; acc = '0;
        foreach (recs[i]) begin
            if (prev_idle > GAP_BITS) nbytes = 0;
            if (!recs[i].stop_ok) begin
                e_frm++; nbytes = 0;
            end else if (!recs[i].par_ok) begin
                e_par++; nbytes = 0;
            end else begin
                acc = {acc[7:0], recs[i].d};
                nbytes++;
                if (nbytes == 2) begin
                    exp_q.push_back(acc);
                    nbytes = 0;
                end
            end
            prev_idle = recs[i].idle;
        end
        n_cmp++;
        if (n_par != e_par || n_frm != e_frm) begin
            n_bad++;
            $display("FAIL random_errs: par %0d frm %0d, expected %0d %0d", n_par, n_frm, e_par, e_frm);
        end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL random_count: %0d words, expected %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL random_word[%0d]: %h, expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_parity();
        test_overrun();
        test_gap_frame();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
